alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 6: operand and result width in bits.
REQ-002 clock  input  1  system clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 EQ.
REQ-006 A  input  WIDTH  operand A; captured when start is accepted.
REQ-007 B  input  WIDTH  operand B; captured when start is accepted.
REQ-008 busy  output  1  high in EXEC and DONE.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 result  output  WIDTH  operation result; held until the next accepted start.
REQ-011 ezero_result  output  WIDTH  value 1 when result is all zeros, else 0; updated with result.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, DONE; IDLE->EXEC on start=1; EXEC->DONE when the iteration count reaches zero; DONE->IDLE unconditionally.
REQ-013 On acceptance, A, B and op SHALL be registered; input changes afterwards SHALL NOT affect the operation in flight.
REQ-014 start in EXEC or DONE SHALL be ignored, not queued.
REQ-015 ADD, SUB, AND, OR, XOR, EQ SHALL spend exactly 1 cycle in EXEC; done is asserted 2 cycles after the accepting edge.
REQ-016 MUL SHALL be shift-add, one bit of B per cycle, WIDTH cycles in EXEC; result = low WIDTH bits of A*B.
REQ-017 SHL SHALL shift A left one bit per cycle for B[2:0] cycles; B[2:0]=0 SHALL still take 1 EXEC cycle and return A unchanged.
REQ-018 ADD/SUB/MUL/SHL SHALL wrap modulo 2^WIDTH; overflow bits discarded.
REQ-019 EQ SHALL give result 1 when A==B, else 0.
REQ-020 result and ezero_result SHALL update only on the EXEC->DONE edge; done SHALL be high only in DONE.
REQ-021 ezero_result SHALL be derived from the final result, never from intermediate partial values.
REQ-022 start asserted in the DONE cycle SHALL be ignored; the next request is accepted from IDLE at the earliest.

Reset
REQ-023 reset SHALL force IDLE and busy=0, done=0, result=0, ezero_result=1, carry=0 (when present), iteration counter=0.
REQ-024 reset mid-operation SHALL abort without a done pulse; reset takes priority over start in the same cycle.

Configuration
REQ-025 Macro ALU_SEQ_CARRY_EN: when defined, an output carry (1 bit) SHALL exist, set to the ADD carry-out / SUB borrow on the EXEC->DONE edge and 0 for other ops; when undefined, the port and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-026 After reset, no start -> result=0, ezero_result=1, busy=0, done=0.
REQ-027 ADD A=5,B=59 -> done 2 cycles after accept, result=0, ezero_result=1 (carry=1 when ALU_SEQ_CARRY_EN).
REQ-028 MUL A=7,B=9 -> done after 6 EXEC cycles, result=63, ezero_result=0; start pulses while busy ignored.
REQ-029 SHL A=3,B=4 -> result=48 after 4 EXEC cycles; SHL A=33,B=0 -> result=33 after 1 EXEC cycle.
REQ-030 EQ A=B=$urandom_range(12,89) -> result=1, ezero_result=0; EQ A=12,B=13 -> result=0, ezero_result=1.
REQ-031 reset asserted during the 3rd EXEC cycle of MUL -> no done, state IDLE, outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit.
// Build option: ALU_SEQ_CARRY_EN adds the carry/borrow response bit.
interface alu_seq_unit_if #(
   parameter int unsigned WIDTH = 6
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] ezero_result;
`ifdef ALU_SEQ_CARRY_EN
   logic             carry;

   modport master (output start, op, A, B,
                   input busy, done, result, ezero_result, carry);
   modport slave  (input start, op, A, B,
                   output busy, done, result, ezero_result, carry);
`else
   modport master (output start, op, A, B,
                   input busy, done, result, ezero_result);
   modport slave  (input start, op, A, B,
                   output busy, done, result, ezero_result);
`endif
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// bit-serial SHL. Build option: ALU_SEQ_CARRY_EN adds an ADD carry / SUB borrow output.
module alu_seq_unit #(
   parameter int unsigned WIDTH = 6
) (
   input logic           clock,
   input logic           reset,
   alu_seq_unit_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOr  = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpMul = 3'd5;
   localparam logic [2:0] OpShl = 3'd6;
   localparam logic [2:0] OpEq  = 3'd7;

   // Counter must hold WIDTH (MUL) and 7 (longest SHL).
   localparam int unsigned CntW = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;
   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] ezero_q, ezero_d;

   logic [WIDTH-1:0] step_res;
   logic [WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0] a_shl;
   logic             shl_active;

`ifdef ALU_SEQ_CARRY_EN
   logic             carry_q, carry_d;
   logic             step_carry;
   logic [WIDTH:0]   add_ext;
   logic [WIDTH:0]   sub_ext;
`endif

   // Datapath for the current EXEC cycle; value is the final result on the last cycle.
   always_comb begin
      acc_sum    = acc_q + (b_q[0] ? a_q : '0);
      a_shl      = a_q << 1;
      // SHL by zero still spends one EXEC cycle but leaves A untouched.
      shl_active = (b_q[2:0] != 3'd0);
      step_res   = '0;
`ifdef ALU_SEQ_CARRY_EN
      add_ext    = {1'b0, a_q} + {1'b0, b_q};
      sub_ext    = {1'b0, a_q} - {1'b0, b_q};
      step_carry = 1'b0;
`endif
      unique case (op_q)
`ifdef ALU_SEQ_CARRY_EN
         OpAdd: begin
            step_res   = add_ext[WIDTH-1:0];
            step_carry = add_ext[WIDTH];
         end
         OpSub: begin
            step_res   = sub_ext[WIDTH-1:0];
            step_carry = sub_ext[WIDTH];
         end
`else
         OpAdd: step_res = a_q + b_q;
         OpSub: step_res = a_q - b_q;
`endif
         OpAnd: step_res = a_q & b_q;
         OpOr:  step_res = a_q | b_q;
         OpXor: step_res = a_q ^ b_q;
         OpMul: step_res = acc_sum;
         OpShl: step_res = shl_active ? a_shl : a_q;
         OpEq:  step_res = (a_q == b_q) ? One : '0;
      endcase
   end

   // Next-state logic: accept in IDLE, iterate in EXEC, publish on EXEC->DONE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ezero_d  = ezero_q;
`ifdef ALU_SEQ_CARRY_EN
      carry_d  = carry_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StExec;
               op_d    = bus.op;
               a_d     = bus.A;
               b_d     = bus.B;
               acc_d   = '0;
               if (bus.op == OpMul) begin
                  cnt_d = CntW'(WIDTH);
               end else if (bus.op == OpShl && bus.B[2:0] != 3'd0) begin
                  cnt_d = CntW'(bus.B[2:0]);
               end else begin
                  cnt_d = CntW'(1);
               end
            end
         end
         StExec: begin
            cnt_d = cnt_q - CntW'(1);
            if (op_q == OpMul) begin
               acc_d = acc_sum;
               a_d   = a_shl;
               b_d   = b_q >> 1;
            end else if (op_q == OpShl && shl_active) begin
               a_d = a_shl;
            end
            if (cnt_q <= CntW'(1)) begin
               state_d  = StDone;
               result_d = step_res;
               ezero_d  = (step_res == '0) ? One : '0;
`ifdef ALU_SEQ_CARRY_EN
               carry_d  = step_carry;
`endif
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= 3'd0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ezero_q  <= One;
`ifdef ALU_SEQ_CARRY_EN
         carry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ezero_q  <= ezero_d;
`ifdef ALU_SEQ_CARRY_EN
         carry_q  <= carry_d;
`endif
      end
   end

   assign bus.busy         = (state_q != StIdle);
   assign bus.done         = (state_q == StDone);
   assign bus.result       = result_q;
   assign bus.ezero_result = ezero_q;
`ifdef ALU_SEQ_CARRY_EN
   assign bus.carry        = carry_q;
`endif
endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit against an arithmetic reference model.
module tb_alu_seq_unit;
   localparam int unsigned W    = 6;
   localparam int unsigned Mask = (1 << W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   alu_seq_unit_if #(.WIDTH(W)) bus ();
   alu_seq_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

   function automatic int unsigned ref_result(input int unsigned op, input int unsigned a,
                                              input int unsigned b);
      case (op)
         0: return (a + b) & Mask;
         1: return (a - b) & Mask;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (a * b) & Mask;
         6: return (a << (b % 8)) & Mask;
         default: return (a == b) ? 1 : 0;
      endcase
   endfunction

   function automatic int unsigned ref_cycles(input int unsigned op, input int unsigned b);
      if (op == 5) return W;
      if (op == 6) return ((b % 8) == 0) ? 1 : (b % 8);
      return 1;
   endfunction

   function automatic int unsigned ref_carry(input int unsigned op, input int unsigned a,
                                             input int unsigned b);
`ifdef ALU_SEQ_CARRY_EN
      if (op == 0) return ((a + b) >> W) & 1;
      if (op == 1) return (a < b) ? 1 : 0;
`endif
      return 0;
   endfunction

   function automatic int unsigned cur_carry();
`ifdef ALU_SEQ_CARRY_EN
      return int'(bus.carry);
`else
      return 0;
`endif
   endfunction

   // Issues one request, scrambles the inputs afterwards, waits for done.
   // Returns sampled in the DONE cycle; poke keeps retrying start while busy.
   task automatic run_op(input int unsigned op, input int unsigned a, input int unsigned b,
                         input bit poke, output int unsigned res, output int unsigned ez,
                         output int unsigned cy, output int unsigned cycles, output bit tmo);
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = 3'(op);
      bus.A     = W'(a);
      bus.B     = W'(b);
      @(negedge clock);
      bus.start = 1'b0;
      bus.op    = 3'($urandom);
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
      cycles    = 0;
      tmo       = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (bus.done === 1'b1) begin
            tmo = 1'b0;
            break;
         end
         if (bus.busy === 1'b1) cycles++;
         if (poke) begin
            bus.start = 1'b1;
            bus.op    = 3'($urandom);
            bus.A     = W'($urandom);
            bus.B     = W'($urandom);
         end
         @(negedge clock);
      end
      bus.start = 1'b0;
      res = int'(bus.result);
      ez  = int'(bus.ezero_result);
      cy  = cur_carry();
   endtask

   task automatic test_reset();
      int unsigned saw_done;
      reset = 1'b1;
      bus.start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b expected 0", bus.done);
      end
      checks++;
      if (bus.result !== W'(0)) begin
         errors++; $display("FAIL reset_result: got %0d expected 0", bus.result);
      end
      checks++;
      if (bus.ezero_result !== W'(1)) begin
         errors++; $display("FAIL reset_ezero: got %0d expected 1", bus.ezero_result);
      end
      checks++;
      if (cur_carry() != 0) begin
         errors++; $display("FAIL reset_carry: got %0d expected 0", cur_carry());
      end
      saw_done = 0;
      repeat (5) begin
         @(negedge clock);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done++;
      end
      checks++;
      if (saw_done != 0) begin
         errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", saw_done);
      end
   endtask

   // One directed request with full checking of result, flag, carry and latency.
   task automatic test_directed(input string name, input int unsigned op, input int unsigned a,
                                input int unsigned b, input bit poke);
      int unsigned res, ez, cy, cyc, er;
      bit tmo;
      run_op(op, a, b, poke, res, ez, cy, cyc, tmo);
      er = ref_result(op, a, b);
      checks++;
      if (tmo) begin
         errors++; $display("FAIL %s_timeout: got no done expected done", name);
      end
      checks++;
      if (res != er) begin
         errors++; $display("FAIL %s_result: got %0d expected %0d", name, res, er);
      end
      checks++;
      if (ez != ((er == 0) ? 1 : 0)) begin
         errors++; $display("FAIL %s_ezero: got %0d expected %0d", name, ez, (er == 0) ? 1 : 0);
      end
      checks++;
      if (cyc != ref_cycles(op, b)) begin
         errors++; $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, ref_cycles(op, b));
      end
      checks++;
      if (cy != ref_carry(op, a, b)) begin
         errors++; $display("FAIL %s_carry: got %0d expected %0d", name, cy, ref_carry(op, a, b));
      end
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL %s_busy_in_done: got %b expected 1", name, bus.busy);
      end
   endtask

   task automatic test_add();
      test_directed("add_5_59", 0, 5, 59, 1'b0);
      test_directed("sub_3_5", 1, 3, 5, 1'b0);
   endtask

   task automatic test_mul();
      test_directed("mul_7_9", 5, 7, 9, 1'b1);
      test_directed("mul_63_63", 5, 63, 63, 1'b0);
   endtask

   task automatic test_shl();
      test_directed("shl_3_4", 6, 3, 4, 1'b0);
      test_directed("shl_33_0", 6, 33, 0, 1'b0);
   endtask

   task automatic test_eq();
      int unsigned v;
      v = $urandom_range(12, 89) & Mask;
      test_directed("eq_same", 7, v, v, 1'b0);
      test_directed("eq_12_13", 7, 12, 13, 1'b0);
   endtask

   task automatic test_random();
      int unsigned op, a, b, res, ez, cy, cyc, er;
      bit tmo;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 7);
         a  = $urandom & Mask;
         b  = $urandom & Mask;
         run_op(op, a, b, (i % 3) == 0, res, ez, cy, cyc, tmo);
         er = ref_result(op, a, b);
         checks++;
         if (tmo || res != er || ez != ((er == 0) ? 1 : 0) || cyc != ref_cycles(op, b) ||
             cy != ref_carry(op, a, b)) begin
            errors++;
            $display("FAIL random op=%0d a=%0d b=%0d: got res=%0d ez=%0d cy=%0d cyc=%0d tmo=%0b expected res=%0d cy=%0d cyc=%0d",
                     op, a, b, res, ez, cy, cyc, tmo, er, ref_carry(op, a, b), ref_cycles(op, b));
         end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned res, ez, cy, cyc;
      bit tmo;
      run_op(4, 45, 18, 1'b0, res, ez, cy, cyc, tmo);
      // start during DONE must not be accepted
      bus.start = 1'b1;
      bus.op    = 3'd0;
      bus.A     = W'(1);
      bus.B     = W'(1);
      @(negedge clock);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL done_start_ignored: got busy=%b expected 0", bus.busy);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL done_pulse_width: got done=%b expected 0", bus.done);
      end
      checks++;
      if (bus.result !== W'(45 ^ 18)) begin
         errors++; $display("FAIL result_hold: got %0d expected %0d", bus.result, 45 ^ 18);
      end
      test_directed("b2b_or", 3, 10, 5, 1'b0);
   endtask

   task automatic test_reset_mid_mul();
      int unsigned res, ez, cy, cyc, active;
      bit tmo;
      run_op(0, 1, 2, 1'b0, res, ez, cy, cyc, tmo);
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = 3'd5;
      bus.A     = W'(7);
      bus.B     = W'(9);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (2) @(negedge clock);
      // third EXEC cycle: reset wins over a simultaneous start
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.op    = 3'd0;
      @(negedge clock);
      reset     = 1'b0;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL midreset_state: got busy=%b done=%b expected 0 0",
                            bus.busy, bus.done);
      end
      checks++;
      if (bus.result !== W'(0) || bus.ezero_result !== W'(1) || cur_carry() != 0) begin
         errors++; $display("FAIL midreset_outputs: got res=%0d ez=%0d cy=%0d expected 0 1 0",
                            bus.result, bus.ezero_result, cur_carry());
      end
      active = 0;
      repeat (W + 3) begin
         @(negedge clock);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) active++;
      end
      checks++;
      if (active != 0) begin
         errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", active);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.A     = '0;
      bus.B     = '0;
      test_reset();
      test_add();
      test_mul();
      test_shl();
      test_eq();
      test_back_to_back();
      test_random();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
